mips_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction words consumed by the MIPS decoder. Holds the PC, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC and PC+4 over a valid/ready interface. It also accepts control-flow redirects from branch/jump resolution and a halt from syscall handling.

---
 rtl/mips_fetch.sv | 139 +++++++++++++
 tb/tb_mips_fetch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch.sv
// mips_fetch: MIPS instruction fetch unit. Holds the PC, reads instruction memory
// over a req/ack handshake, and presents each word with its PC and PC+4 on a
// valid/ready interface. It also accepts redirects from branch/jump resolution
// and a sticky halt from syscall handling.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   imem_req/addr/ack/rdata   instruction memory read handshake
//   inst_valid/ready          instruction output handshake
//   inst/inst_pc/inst_pc4     instruction word, its address, and the link value
//   redirect/redirect_pc      redirect request and target for the next fetch
//   halt                      stops fetching until rst
//   fetch_err                 a misaligned redirect was seen (alignment check builds only)
//
// Optional feature: MIPS_FETCH_ALIGN_CHECK_EN.
//   Defined:   a redirect taken with redirect_pc[1:0] != 0 enters the sticky ERR state.
//   Undefined: redirect_pc[1:0] is forced to 00 and fetch_err is tied low.
//
// Every output is decoded from registers, so no input reaches an output
// through combinational logic.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DISCARD,
    S_HOLD,
    S_HALTED
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    , S_ERR
`endif
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redir_pend;  // outstanding read must be dropped; redir_pc is the next pc
  logic [31:0] redir_pc;
  logic [31:0] tgt;

`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  logic bad_tgt;
  assign bad_tgt = |redirect_pc[1:0];
  assign tgt     = redirect_pc;
`else
  assign tgt     = redirect_pc & ~32'd3;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      inst_pc    <= 32'd0;
      redir_pend <= 1'b0;
      redir_pc   <= 32'd0;
    end else begin
      case (state)
        // FETCH and DISCARD share one handshake. redir_pend decides whether
        // the data that arrives is kept or dropped.
        S_FETCH, S_DISCARD: begin
          if (halt) begin
            state      <= S_HALTED;
            redir_pend <= 1'b0;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
          end else if (redirect && bad_tgt) begin
            state      <= S_ERR;
            redir_pend <= 1'b0;
`endif
          end else if (imem_ack) begin
            redir_pend <= 1'b0;
            if (redirect) begin
              // A redirect in the same cycle as the ack wins over an older pending one.
              pc    <= tgt;
              state <= S_FETCH;
            end else if (redir_pend) begin
              pc    <= redir_pc;
              state <= S_FETCH;
            end else begin
              inst    <= imem_rdata;
              inst_pc <= pc;
              pc      <= pc + 32'd4;
              state   <= S_HOLD;
            end
          end else if (redirect) begin
            // The request cannot be withdrawn. Remember the target and drop the data when it arrives.
            redir_pc   <= tgt;
            redir_pend <= 1'b1;
            state      <= S_DISCARD;
          end
        end
        S_HOLD: begin
          if (halt) begin
            state <= S_HALTED;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
          end else if (redirect && bad_tgt) begin
            state <= S_ERR;
`endif
          end else if (redirect) begin
            pc    <= tgt;
            state <= S_FETCH;
          end else if (inst_ready) begin
            state <= S_FETCH;
          end
        end
        default: begin
          // HALTED and ERR are left only through rst.
        end
      endcase
    end
  end

  assign imem_req   = (state == S_FETCH) || redir_pend;
  assign imem_addr  = pc;
  assign inst_valid = (state == S_HOLD);
  assign inst_pc4   = inst_pc + 32'd4;
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
  assign fetch_err  = (state == S_ERR);
`else
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed test-plan scenarios followed by random traffic. All
// traffic is checked every cycle against a transaction-level model of the fetch
// unit. Instruction memory returns a fixed function of the address.
module tb_mips_fetch;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst, inst_pc, inst_pc4;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halt = 1'b0;
  logic        fetch_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt), .fetch_err(fetch_err)
  );

  // Contents of instruction memory.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, kept at transaction level.
  bit          m_busy;   // a memory read is outstanding
  bit          m_drop;   // the outstanding read's data is thrown away
  logic [31:0] m_pc;     // address of the current or next read
  logic [31:0] m_tgt;    // where fetching resumes after a dropped read
  bit          m_full;   // an instruction is on offer downstream
  logic [31:0] m_i, m_ipc;
  bit          m_stop, m_err;

  function automatic bit misal(input logic [31:0] p);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    return p[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] align(input logic [31:0] p);
    return p & ~32'd3;
  endfunction

  task automatic model_step(input bit r, input bit a, input bit y, input bit d,
                            input logic [31:0] p, input bit h);
    if (r) begin
      m_busy = 1; m_drop = 0; m_pc = RPC; m_full = 0;
      m_i = 0; m_ipc = 0; m_stop = 0; m_err = 0;
    end else if (m_stop || m_err) begin
      // frozen until reset
    end else if (h) begin
      m_busy = 0; m_full = 0; m_drop = 0; m_stop = 1;
    end else if (d && misal(p)) begin
      m_busy = 0; m_full = 0; m_drop = 0; m_err = 1;
    end else if (m_busy) begin
      if (a) begin
        if (d) m_pc = align(p);
        else if (m_drop) m_pc = m_tgt;
        else begin
          m_i = memf(m_pc); m_ipc = m_pc; m_pc = m_pc + 4;
          m_busy = 0; m_full = 1;
        end
        m_drop = 0;
      end else if (d) begin
        m_drop = 1; m_tgt = align(p);
      end
    end else if (m_full) begin
      if (d) begin m_pc = align(p); m_full = 0; m_busy = 1; end
      else if (y) begin m_full = 0; m_busy = 1; end
    end
  endtask

  // One cycle, starting and ending at a negedge: check the outputs against the
  // model, drive the inputs, advance the model, and let the posedge pass.
  task automatic cyc(input bit r, input bit a, input bit y, input bit d,
                     input logic [31:0] p, input bit h);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_busy});
    if (m_busy) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_full});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    if (m_full) begin
      chk("inst", inst, m_i);
      chk("inst_pc", inst_pc, m_ipc);
      chk("inst_pc4", inst_pc4, m_ipc + 32'd4);
    end
    rst = r; imem_ack = a; inst_ready = y; redirect = d; redirect_pc = p; halt = h;
    imem_rdata = imem_req ? memf(imem_addr) : $urandom;
    model_step(r, a, y, d, p, h);
    @(negedge clk);
  endtask

  initial begin
    m_busy = 1; m_drop = 0; m_pc = RPC; m_tgt = 0; m_full = 0;
    m_i = 0; m_ipc = 0; m_stop = 0; m_err = 0;
    @(negedge clk);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    // Reset values
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0040_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_pc4", inst_pc4, 32'd4);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    // ack and ready held high: one instruction every two cycles
    cyc(0, 1, 1, 0, 0, 0);
    chk("first_valid", {31'd0, inst_valid}, 32'd1);
    chk("first_pc4", inst_pc4, 32'h0040_0004);
    cyc(0, 1, 1, 0, 0, 0);
    chk("second_addr", imem_addr, 32'h0040_0004);
    // Stall for five cycles in HOLD
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, 0, 0, 0);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_pc", inst_pc, 32'h0040_0004);
    end
    cyc(0, 1, 1, 0, 0, 0);
    chk("after_stall_addr", imem_addr, 32'h0040_0008);
    // Redirect taken in HOLD
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0040_0100, 0);
    chk("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h0040_0100);
    // Redirect while the ack is late: the old address is held, then the data is dropped
    cyc(0, 0, 0, 1, 32'h0040_0200, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("discard_addr", imem_addr, 32'h0040_0100);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("discard_valid", {31'd0, inst_valid}, 32'd0);
    chk("discard_next", imem_addr, 32'h0040_0200);
    // Halt in HOLD, then reset
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 32'h0040_0300, 1'($urandom));
      chk("halted_req", {31'd0, imem_req}, 32'd0);
    end
    cyc(1, 0, 0, 0, 0, 0);
    chk("halt_rst_addr", imem_addr, 32'h0040_0000);
    // Misaligned redirect target
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h0040_0102, 0);
`ifdef MIPS_FETCH_ALIGN_CHECK_EN
    chk("misal_err", {31'd0, fetch_err}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 1, 0, 0, 0);
      chk("err_req", {31'd0, imem_req}, 32'd0);
    end
`else
    chk("misal_addr", imem_addr, 32'h0040_0100);
`endif
    cyc(1, 0, 0, 0, 0, 0);
    // Random traffic, including targets near the top of the address space to exercise wrap
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                      : (RPC | ($urandom & 32'h0000_0FFC));
      if ($urandom_range(0, 40) == 0) p[1:0] = 2'($urandom_range(1, 3));
      cyc($urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 11) == 0,
          p,
          $urandom_range(0, 299) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
